// File: rtl/ast_skew_feeder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : ast_feeder_pkg                                                |
// | Purpose  : Shared types and constants for the systolic operand feeder.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ast_feeder_pkg;

    localparam int c_size      = 4;
    localparam int c_datawidth = 14;
    localparam int c_depth     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    typedef logic [c_datawidth-1:0] operand_t;

    typedef struct {
        operand_t a[c_size];
        operand_t b[c_size];
    } slice_t;

    // Must cover both the slice count and the longest stream index K+2*SIZE-3.
    function automatic int feeder_cnt_width(input int depth, input int size);
        return $clog2(depth + 2 * size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ast_skew_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : ast_skew_feeder_if                                           |
// | Purpose   : Slice write channel from the operand loader into the feeder. |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface ast_skew_feeder_if #(
    parameter int SIZE      = ast_feeder_pkg::c_size,
    parameter int DATAWIDTH = ast_feeder_pkg::c_datawidth
);

    logic                           wr_valid;
    logic                           wr_ready;
    logic                           wr_last;
    logic [SIZE-1:0][DATAWIDTH-1:0] wr_a;
    logic [SIZE-1:0][DATAWIDTH-1:0] wr_b;

    modport master (
        output wr_valid,
        output wr_last,
        output wr_a,
        output wr_b,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_last,
        input  wr_a,
        input  wr_b,
        output wr_ready
    );

endinterface
`default_nettype wire

// File: rtl/ast_skew_feeder_delay.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ast_skew_delay                                                |
// | Purpose  : Single-lane shift register providing the diagonal skew.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ast_skew_delay #(
    parameter int DELAY = 0,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_pass
            // Lane 0 sees the already-registered feed directly.
            logic w_unused;
            assign w_unused = clk ^ rst ^ clr;
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_pipe [DELAY];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int n = 0; n < DELAY; n++) begin
                        r_pipe[n] <= '0;
                    end
                end else begin
                    r_pipe[0] <= din;
                    for (int n = 1; n < DELAY; n++) begin
                        r_pipe[n] <= r_pipe[n-1];
                    end
                end
            end

            assign dout = r_pipe[DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ast_skew_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ast_skew_feeder                                               |
// | Purpose  : Buffers K operand slices and streams them diagonally skewed   |
// |            into a SIZE x SIZE systolic array with load/mult/acc control. |
// |            Define AST_FEEDER_PERF_EN to add the run_count output.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ast_skew_feeder
    import ast_feeder_pkg::*;
#(
    parameter int SIZE      = c_size,
    parameter int DATAWIDTH = c_datawidth,
    parameter int DEPTH     = c_depth
) (
    input  logic                           clk,
    input  logic                           reset,
    ast_skew_feeder_if.slave               wr,
    output logic [SIZE-1:0][DATAWIDTH-1:0] a_out,
    output logic [SIZE-1:0][DATAWIDTH-1:0] b_out,
    output logic                           load_en,
    output logic                           mult_en,
    output logic                           acc_en,
    output logic                           busy,
    output logic                           done
`ifdef AST_FEEDER_PERF_EN
    ,
    output logic [15:0]                    run_count
`endif
);

    localparam int c_cw = feeder_cnt_width(DEPTH, SIZE);
    localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cw-1:0] c_one        = c_cw'(1);
    localparam logic [c_cw-1:0] c_depth_cnt  = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_last_slice = c_cw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_flush      = c_cw'(2 * SIZE - 2);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;

    logic [c_cw-1:0] r_k;
    logic [c_cw-1:0] w_k_nxt;
    logic [c_cw-1:0] r_t;
    logic [c_cw-1:0] w_t_nxt;
    logic [c_cw-1:0] w_len;
    logic [c_cw-1:0] w_rd_idx;
    logic            w_rd_sel;
    logic            w_rd_hit;
    logic            w_accept;
    logic            w_lane_clr;

    logic [SIZE-1:0][DATAWIDTH-1:0] r_mem_a [DEPTH];
    logic [SIZE-1:0][DATAWIDTH-1:0] r_mem_b [DEPTH];
    logic [SIZE-1:0][DATAWIDTH-1:0] r_feed_a;
    logic [SIZE-1:0][DATAWIDTH-1:0] r_feed_b;

    logic r_wr_ready;
    logic r_load_en;
    logic r_mult_en;
    logic r_acc_en;
    logic r_busy;
    logic r_done;

    assign w_len = r_k + c_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_t_nxt     = r_t;
        w_accept    = 1'b0;
        w_rd_sel    = 1'b0;
        w_rd_idx    = '0;
        case (r_state)
            IDLE: begin
                if (wr.wr_valid && r_wr_ready) begin
                    w_accept = 1'b1;
                    w_k_nxt  = r_k + c_one;
                    if (wr.wr_last || (r_k == c_last_slice)) begin
                        w_state_nxt = CLEAR;
                    end
                end
            end
            CLEAR: begin
                // Pre-load slice 0 so lane 0 shows it on the first stream cycle.
                w_state_nxt = STREAM;
                w_t_nxt     = '0;
                w_rd_sel    = 1'b1;
            end
            STREAM: begin
                if (r_t == (w_len - c_one)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_t_nxt  = r_t + c_one;
                    w_rd_sel = 1'b1;
                    w_rd_idx = r_t + c_one;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
                w_t_nxt     = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Indices at or beyond K feed the trailing flush zeros.
        w_rd_hit = w_rd_sel && (w_rd_idx < r_k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k        <= '0;
            r_t        <= '0;
            r_wr_ready <= 1'b1;
            r_load_en  <= 1'b0;
            r_mult_en  <= 1'b0;
            r_acc_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_feed_a   <= '0;
            r_feed_b   <= '0;
        end else begin
            r_k        <= w_k_nxt;
            r_t        <= w_t_nxt;
            r_wr_ready <= (w_state_nxt == IDLE) && (w_k_nxt < c_depth_cnt);
            r_load_en  <= (w_state_nxt == CLEAR);
            r_mult_en  <= (w_state_nxt == STREAM);
            r_acc_en   <= (w_state_nxt == STREAM);
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= (w_state_nxt == DONE);
            if (w_rd_hit) begin
                r_feed_a <= r_mem_a[w_rd_idx[c_iw-1:0]];
                r_feed_b <= r_mem_b[w_rd_idx[c_iw-1:0]];
            end else begin
                r_feed_a <= '0;
                r_feed_b <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_a[r_k[c_iw-1:0]] <= wr.wr_a;
            r_mem_b[r_k[c_iw-1:0]] <= wr.wr_b;
        end
    end

    // Delay lines only shift while streaming; any other state holds them at zero.
    assign w_lane_clr = (r_state != STREAM);

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
            logic [DATAWIDTH-1:0] w_a_dly;
            logic [DATAWIDTH-1:0] w_b_dly;

            ast_skew_delay #(
                .DELAY (gi),
                .WIDTH (DATAWIDTH)
            ) u_dly_a (
                .clk  (clk),
                .rst  (reset),
                .clr  (w_lane_clr),
                .din  (r_feed_a[gi]),
                .dout (w_a_dly)
            );

            ast_skew_delay #(
                .DELAY (gi),
                .WIDTH (DATAWIDTH)
            ) u_dly_b (
                .clk  (clk),
                .rst  (reset),
                .clr  (w_lane_clr),
                .din  (r_feed_b[gi]),
                .dout (w_b_dly)
            );

            assign a_out[gi] = w_a_dly;
            assign b_out[gi] = w_b_dly;
        end
    endgenerate

`ifdef AST_FEEDER_PERF_EN
    logic [15:0] r_run_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_count <= '0;
        end else if ((w_state_nxt == DONE) && (r_run_count != 16'hFFFF)) begin
            r_run_count <= r_run_count + 16'd1;
        end
    end

    assign run_count = r_run_count;
`endif

    assign wr.wr_ready = r_wr_ready;
    assign load_en     = r_load_en;
    assign mult_en     = r_mult_en;
    assign acc_en      = r_acc_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire
